ex_alu_pipe: RTL and testbench
==============================

Name: ex_alu_pipe

Overview:
- Parametrised integer ALU execute unit for the Raisin64 backend: dispatch feeds operands, unit/op and destination tag; the result reaches commit after DEPTH cycles.
- Successor to the single-cycle ALU: configurable datapath width, pipeline depth and tag width.
- Adds real backpressure: per-stage valid bits with bubble collapse, results held under stall, and a flush input for branch mispredict and exception kill.

Parameters:
- W, 64: datapath width (power of two, >= 8).
- DEPTH, 2: pipeline stages from dispatch to commit (>= 1).
- RN_W, 6: destination register tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in1  in  W  operand A.
- in2  in  W  operand B (shift amount in in2[log2(W)-1:0]).
- ex_enable  in  1  dispatch issues an operation this cycle.
- ex_busy  out  1  unit cannot accept an operation this cycle.
- rd_in_rn  in  RN_W  destination tag from dispatch.
- unit  in  3  function group.
- op  in  2  operation within group.
- flush  in  1  kill all in-flight operations.
- out  out  W  result to commit.
- rd_out_rn  out  RN_W  destination tag of out.
- valid  out  1  out/rd_out_rn hold a live result.
- stall  in  1  commit cannot take the result this cycle.

Behaviour:
- Function table, combinational at stage 0:
  - unit 0: op0 ADD, op1 SUB, op2 SLT (signed, result 0/1), op3 SLTU.
  - unit 1: op0 AND, op1 OR, op2 XOR, op3 NOR.
  - unit 2: op0 SLL, op1 SRL, op2 SRA, op3 ROL.
  - unit 3-7: result 0.
  - All arithmetic wraps modulo 2^W; no flags.
- Stages 0..DEPTH-1 each hold {v, result, tag}. Stage DEPTH-1 drives valid/out/rd_out_rn.
- Advance rules:
  - Last stage advances when v & ~stall.
  - Stage i (i < DEPTH-1) advances when v[i] & (~v[i+1] | adv[i+1]).
  - An advancing stage hands its contents to the next; a non-advancing stage holds.
  - Bubbles collapse: an empty stage accepts from the stage before it even while commit stalls.
- Acceptance: ready = ~v[0] | adv[0], and ex_busy = ~ready (combinational).
  - ex_enable & ready loads stage 0 with {1, alu_result, rd_in_rn}.
  - ex_enable while ex_busy: operation dropped. Simulation-only assertion flags it.
- Latency: exactly DEPTH cycles from accepting edge to valid=1 with no stall. Throughput 1/cycle.
- Under stall: out, rd_out_rn and valid stay stable until the cycle stall=0. At most DEPTH operations are in flight.
- Ordering: results retire strictly in issue order; none duplicated or lost.
- flush:
  - Synchronous; clears every v bit at the next edge, including the stall-held output. Flush overrides stall.
  - ex_enable in the same cycle is also discarded.
  - ex_busy is not forced by flush.
- Reset: async. All v=0, valid=0, out=0, rd_out_rn=0, all stage data 0, so ex_busy=0 after reset. Reset mid-operation discards in-flight work.
- DEPTH=1: single-cycle unit whose ex_busy = valid & stall (not raw stall).

Decomposition:
- Shared package ex_pkg: unit codes (EX_UNIT_ARITH=0, EX_UNIT_LOGIC=1, EX_UNIT_SHIFT=2) and op encodings per group, shared with the decoder and dispatch.
- Sub-module ex_alu_core: purely combinational function table, parametrised by W.
- ex_alu_pipe holds the stage array, the advance/ready logic and flush.

Test Plan:
- Reset then single ADD (DEPTH=2, W=64): in1=5, in2=0xFFFF_FFFF_FFFF_FFFE, rd=7 -> 2 cycles later valid=1, out=3, rd_out_rn=7; one cycle later valid=0.
- Function sweep: SUB 3-5 -> 0xFFFF_FFFF_FFFF_FFFE; SLT -1<1 -> 1; SLTU -1<1 -> 0; NOR 0,0 -> all ones; SRA 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000; ROL 0x8000_0000_0000_0001 by 1 -> 3; unit 5 -> 0.
- Back-to-back issue of tags 1,2,3 with stall high from cycle 2:
  - Output holds tag 1 stable.
  - Bubbles collapse; ex_busy rises only once DEPTH operations are held.
  - On stall release, tags 1,2,3 retire on consecutive cycles.
- Full-pipe issue while ex_busy=1 -> operation dropped, assertion fires, no extra valid.
- flush with 2 in flight and stall=1, plus ex_enable in the same cycle -> next cycle valid=0, nothing retires, ex_busy=0.
- Assert rst_n mid-stream with valid=1 -> outputs 0 immediately (async); resume -> first new op retires after DEPTH cycles.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared execute-unit encodings: function-group codes and per-group op codes,
// common to the decoder, dispatch and the ALU execute pipe.
package ex_pkg;

   localparam int EX_UNIT_W = 3;
   localparam int EX_OP_W   = 2;

   typedef enum logic [EX_UNIT_W-1:0] {
      EX_UNIT_ARITH = 3'd0,
      EX_UNIT_LOGIC = 3'd1,
      EX_UNIT_SHIFT = 3'd2
   } ex_unit_e;

   typedef enum logic [EX_OP_W-1:0] {
      EX_OP_ADD  = 2'd0,
      EX_OP_SUB  = 2'd1,
      EX_OP_SLT  = 2'd2,
      EX_OP_SLTU = 2'd3
   } ex_arith_op_e;

   typedef enum logic [EX_OP_W-1:0] {
      EX_OP_AND = 2'd0,
      EX_OP_OR  = 2'd1,
      EX_OP_XOR = 2'd2,
      EX_OP_NOR = 2'd3
   } ex_logic_op_e;

   typedef enum logic [EX_OP_W-1:0] {
      EX_OP_SLL = 2'd0,
      EX_OP_SRL = 2'd1,
      EX_OP_SRA = 2'd2,
      EX_OP_ROL = 2'd3
   } ex_shift_op_e;

endpackage

// File: rtl/ex_alu_core.sv
// Combinational integer function table: arithmetic/compare, bitwise logic and
// shift/rotate groups. Everything wraps modulo 2^W; no flags are produced.
module ex_alu_core
   import ex_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0]         in1,
   input  logic [W-1:0]         in2,
   input  logic [EX_UNIT_W-1:0] unit,
   input  logic [EX_OP_W-1:0]   op,
   output logic [W-1:0]         result
);

   localparam int SHW = $clog2(W);

   logic [SHW-1:0] sh;
   logic [W-1:0]   arith_res;
   logic [W-1:0]   logic_res;
   logic [W-1:0]   shift_res;

   assign sh = in2[SHW-1:0];

   always_comb begin
      arith_res = '0;
      case (op)
         EX_OP_ADD:  arith_res = in1 + in2;
         EX_OP_SUB:  arith_res = in1 - in2;
         EX_OP_SLT:  arith_res = {{(W-1){1'b0}}, ($signed(in1) < $signed(in2))};
         EX_OP_SLTU: arith_res = {{(W-1){1'b0}}, (in1 < in2)};
         default:    arith_res = '0;
      endcase
   end

   always_comb begin
      logic_res = '0;
      case (op)
         EX_OP_AND: logic_res = in1 & in2;
         EX_OP_OR:  logic_res = in1 | in2;
         EX_OP_XOR: logic_res = in1 ^ in2;
         EX_OP_NOR: logic_res = ~(in1 | in2);
         default:   logic_res = '0;
      endcase
   end

   // A shift by W yields zero, so a rotate by 0 degenerates to in1 without a special case.
   always_comb begin
      shift_res = '0;
      case (op)
         EX_OP_SLL: shift_res = in1 << sh;
         EX_OP_SRL: shift_res = in1 >> sh;
         EX_OP_SRA: shift_res = $signed(in1) >>> sh;
         EX_OP_ROL: shift_res = (in1 << sh) | (in1 >> (W - int'(sh)));
         default:   shift_res = '0;
      endcase
   end

   always_comb begin
      result = '0;
      case (unit)
         EX_UNIT_ARITH: result = arith_res;
         EX_UNIT_LOGIC: result = logic_res;
         EX_UNIT_SHIFT: result = shift_res;
         default:       result = '0;
      endcase
   end

endmodule

// File: rtl/ex_alu_pipe.sv
// ALU execute pipe: DEPTH stages of {valid, result, tag} with per-stage
// advance, bubble collapse, stall hold at commit and a flush that kills all.
module ex_alu_pipe
   import ex_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 2,
   parameter int RN_W  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         in1,
   input  logic [W-1:0]         in2,
   input  logic                 ex_enable,
   output logic                 ex_busy,
   input  logic [RN_W-1:0]      rd_in_rn,
   input  logic [EX_UNIT_W-1:0] unit,
   input  logic [EX_OP_W-1:0]   op,
   input  logic                 flush,
   output logic [W-1:0]         out,
   output logic [RN_W-1:0]      rd_out_rn,
   output logic                 valid,
   input  logic                 stall
);

   logic [W-1:0]     alu_res;

   logic [DEPTH-1:0] v_q,   v_d;
   logic [W-1:0]     res_q [DEPTH];
   logic [W-1:0]     res_d [DEPTH];
   logic [RN_W-1:0]  tag_q [DEPTH];
   logic [RN_W-1:0]  tag_d [DEPTH];

   logic [DEPTH-1:0] adv;
   logic             ready;

   ex_alu_core #(
      .W (W)
   ) u_core (
      .in1    (in1),
      .in2    (in2),
      .unit   (unit),
      .op     (op),
      .result (alu_res)
   );

   // Advance chain runs from commit backwards: a stage moves if the next one is
   // empty or is itself moving on this edge.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = v_q[DEPTH-1] & ~stall;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
      end
   end

   assign ready   = ~v_q[0] | adv[0];
   assign ex_busy = ~ready;

   always_comb begin
      v_d   = v_q;
      res_d = res_q;
      tag_d = tag_q;

      for (int i = DEPTH - 1; i >= 1; i--) begin
         if (adv[i-1]) begin
            v_d[i]   = 1'b1;
            res_d[i] = res_q[i-1];
            tag_d[i] = tag_q[i-1];
         end else if (adv[i]) begin
            v_d[i] = 1'b0;
         end
      end

      if (ex_enable && ready) begin
         v_d[0]   = 1'b1;
         res_d[0] = alu_res;
         tag_d[0] = rd_in_rn;
      end else if (adv[0]) begin
         v_d[0] = 1'b0;
      end

      // Kill beats everything, including a stall-held result and a same-cycle issue.
      if (flush) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         res_q <= res_d;
         tag_q <= tag_d;
      end
   end

   assign valid     = v_q[DEPTH-1];
   assign out       = res_q[DEPTH-1];
   assign rd_out_rn = tag_q[DEPTH-1];

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(ex_enable && ex_busy))
            else $warning("ex_alu_pipe: operation for tag %0d dropped while busy", rd_in_rn);
      end
   end
`endif

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Scoreboard bench for ex_alu_pipe (W=64, DEPTH=2, RN_W=6): expected results are
// queued at issue and compared in order as commit takes them.
module tb_ex_alu_pipe;

   localparam int W     = 64;
   localparam int DEPTH = 2;
   localparam int RN_W  = 6;

   logic            clk;
   logic            rst_n;
   logic [W-1:0]    in1;
   logic [W-1:0]    in2;
   logic            ex_enable;
   logic            ex_busy;
   logic [RN_W-1:0] rd_in_rn;
   logic [2:0]      unit;
   logic [1:0]      op;
   logic            flush;
   logic [W-1:0]    out;
   logic [RN_W-1:0] rd_out_rn;
   logic            valid;
   logic            stall;

   typedef struct {
      logic [63:0] res;
      logic [5:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   n_retired = 0;
   bit   rand_stall = 0;

   ex_alu_pipe #(
      .W     (W),
      .DEPTH (DEPTH),
      .RN_W  (RN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in1       (in1),
      .in2       (in2),
      .ex_enable (ex_enable),
      .ex_busy   (ex_busy),
      .rd_in_rn  (rd_in_rn),
      .unit      (unit),
      .op        (op),
      .flush     (flush),
      .out       (out),
      .rd_out_rn (rd_out_rn),
      .valid     (valid),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] r, input logic [5:0] t);
      exp_t e;
      e.res = r;
      e.tag = t;
      exp_q.push_back(e);
   endtask

   function automatic logic [63:0] model(input logic [2:0] u, input logic [1:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [5:0] s;
      s = b[5:0];
      case (u)
         3'd0: case (o)
                  2'd0: return a + b;
                  2'd1: return a - b;
                  2'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                  default: return (a < b) ? 64'd1 : 64'd0;
               endcase
         3'd1: case (o)
                  2'd0: return a & b;
                  2'd1: return a | b;
                  2'd2: return a ^ b;
                  default: return ~(a | b);
               endcase
         3'd2: case (o)
                  2'd0: return a << s;
                  2'd1: return a >> s;
                  2'd2: return $signed(a) >>> s;
                  default: return (s == 6'd0) ? a : ((a << s) | (a >> (7'd64 - {1'b0, s})));
               endcase
         default: return 64'd0;
      endcase
   endfunction

   // Called at posedge+1; raises ex_enable only when the unit can take it.
   task automatic issue(input logic [2:0] u, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] t, input logic [63:0] exp);
      bit acc;
      acc      = 1'b0;
      unit     = u;
      op       = o;
      in1      = a;
      in2      = b;
      rd_in_rn = t;
      for (int k = 0; k < 40 && !acc; k++) begin
         #1;
         if (!ex_busy) begin
            ex_enable = 1'b1;
            push(exp, t);
            acc = 1'b1;
         end
         tick();
         ex_enable = 1'b0;
      end
      if (!acc) check("issue_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!valid && cyc < 10) begin
         tick();
         cyc++;
      end
   endtask

   always @(posedge clk) begin
      if (rand_stall) begin
         #1;
         stall = ($urandom_range(0, 2) == 0);
      end
   end

   // Commit side: a result is taken on the edge following a negedge where it is
   // valid, not stalled and not flushed.
   always @(negedge clk) begin
      if (rst_n && valid && !stall && !flush) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out", out, mon_e.res);
            check("rd_out_rn", 64'(rd_out_rn), 64'(mon_e.tag));
            n_retired++;
         end
      end
   end

   initial begin
      int cyc;
      int base;
      logic [2:0]  ru;
      logic [1:0]  ro;
      logic [63:0] ra;
      logic [63:0] rb;

      rst_n     = 1'b0;
      in1       = '0;
      in2       = '0;
      ex_enable = 1'b0;
      rd_in_rn  = '0;
      unit      = '0;
      op        = '0;
      flush     = 1'b0;
      stall     = 1'b0;
      repeat (3) tick();
      check("rst_valid",     64'(valid),     64'd0);
      check("rst_out",       out,            64'd0);
      check("rst_rd_out_rn", 64'(rd_out_rn), 64'd0);
      check("rst_ex_busy",   64'(ex_busy),   64'd0);
      rst_n = 1'b1;
      tick();

      // Single ADD with latency
      issue(3'd0, 2'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 6'd7, 64'd3);
      check("add_not_early", 64'(valid), 64'd0);
      wait_valid(cyc);
      check("add_latency",   64'(cyc),       64'(DEPTH));
      check("add_out",       out,            64'd3);
      check("add_rd_out_rn", 64'(rd_out_rn), 64'd7);
      tick();
      check("add_valid_drop", 64'(valid), 64'd0);

      // Function sweep, back to back
      issue(3'd0, 2'd1, 64'd3, 64'd5, 6'd10, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(3'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd11, 64'd1);
      issue(3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd12, 64'd0);
      issue(3'd1, 2'd3, 64'd0, 64'd0, 6'd13, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(3'd2, 2'd2, 64'h8000_0000_0000_0000, 64'd4, 6'd14, 64'hF800_0000_0000_0000);
      issue(3'd2, 2'd3, 64'h8000_0000_0000_0001, 64'd1, 6'd15, 64'd3);
      issue(3'd5, 2'd0, 64'h1234, 64'h5678, 6'd16, 64'd0);
      issue(3'd1, 2'd0, 64'hF0F0, 64'hFF00, 6'd17, 64'hF000);
      issue(3'd1, 2'd2, 64'hF0F0, 64'hFF00, 6'd18, 64'h0FF0);
      issue(3'd2, 2'd0, 64'd1, 64'd63, 6'd19, 64'h8000_0000_0000_0000);
      issue(3'd2, 2'd1, 64'h8000_0000_0000_0000, 64'd63, 6'd20, 64'd1);
      drain();

      // Stall: tag 1 held, bubble collapses tag 2 behind it, tag 3 waits
      tick();
      unit = 3'd0; op = 2'd0; in1 = 64'd10; in2 = 64'd1; rd_in_rn = 6'd1;
      ex_enable = 1'b1;
      push(64'd11, 6'd1);
      tick();
      ex_enable = 1'b0;
      stall     = 1'b1;
      @(negedge clk);
      check("stall_busy_s0_only", 64'(ex_busy), 64'd0);
      tick();
      in1 = 64'd20; in2 = 64'd2; rd_in_rn = 6'd2;
      ex_enable = 1'b1;
      push(64'd22, 6'd2);
      @(negedge clk);
      check("stall_valid_t1",    64'(valid),     64'd1);
      check("stall_tag_t1",      64'(rd_out_rn), 64'd1);
      check("stall_busy_one",    64'(ex_busy),   64'd0);
      tick();
      in1 = 64'd30; in2 = 64'd3; rd_in_rn = 6'd3;
      @(negedge clk);
      check("stall_hold_tag",  64'(rd_out_rn), 64'd1);
      check("stall_hold_out",  out,            64'd11);
      check("stall_busy_full", 64'(ex_busy),   64'd1);
      tick();
      check("stall_hold_tag2", 64'(rd_out_rn), 64'd1);
      check("stall_hold_vld2", 64'(valid),     64'd1);
      stall = 1'b0;
      push(64'd33, 6'd3);
      base = n_retired;
      @(negedge clk);
      check("release_busy", 64'(ex_busy), 64'd0);
      tick();
      ex_enable = 1'b0;
      @(negedge clk);
      check("retire_t2", 64'(rd_out_rn), 64'd2);
      tick();
      @(negedge clk);
      check("retire_t3", 64'(rd_out_rn), 64'd3);
      tick();
      @(negedge clk);
      check("retire_count", 64'(n_retired - base), 64'd3);
      check("retire_idle",  64'(valid),            64'd0);

      // Issue into a full stalled pipe is dropped
      tick();
      base = n_retired;
      stall = 1'b1;
      unit = 3'd1; op = 2'd1; in1 = 64'h0F; in2 = 64'hF0; rd_in_rn = 6'd21;
      ex_enable = 1'b1;
      push(64'hFF, 6'd21);
      tick();
      in1 = 64'h3; in2 = 64'h4; rd_in_rn = 6'd22;
      push(64'h7, 6'd22);
      tick();
      in1 = 64'h100; in2 = 64'h1; rd_in_rn = 6'd9;
      @(negedge clk);
      check("drop_busy", 64'(ex_busy), 64'd1);
      tick();
      ex_enable = 1'b0;
      stall     = 1'b0;
      repeat (5) tick();
      check("drop_retired", 64'(n_retired - base), 64'd2);
      check("drop_q_empty", 64'(exp_q.size()),     64'd0);
      check("drop_idle",    64'(valid),            64'd0);

      // flush with two in flight under stall plus a same-cycle issue
      stall = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_idle_busy", 64'(ex_busy), 64'd0);
      tick();
      flush = 1'b0;
      unit = 3'd0; op = 2'd0; in1 = 64'd1; in2 = 64'd1; rd_in_rn = 6'd30;
      ex_enable = 1'b1;
      tick();
      rd_in_rn = 6'd31;
      tick();
      rd_in_rn = 6'd32;
      flush    = 1'b1;
      @(negedge clk);
      check("preflush_valid", 64'(valid), 64'd1);
      tick();
      flush     = 1'b0;
      ex_enable = 1'b0;
      base      = n_retired;
      @(negedge clk);
      check("flush_valid", 64'(valid),   64'd0);
      check("flush_busy",  64'(ex_busy), 64'd0);
      stall = 1'b0;
      repeat (4) tick();
      check("flush_none_retired", 64'(n_retired - base), 64'd0);

      // Asynchronous reset with a live held result
      stall = 1'b1;
      issue(3'd0, 2'd0, 64'd40, 64'd2, 6'd40, 64'd42);
      tick();
      @(negedge clk);
      check("prereset_valid", 64'(valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid",     64'(valid),     64'd0);
      check("async_out",       out,            64'd0);
      check("async_rd_out_rn", 64'(rd_out_rn), 64'd0);
      check("async_busy",      64'(ex_busy),   64'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      stall = 1'b0;
      tick();
      issue(3'd0, 2'd1, 64'd100, 64'd1, 6'd41, 64'd99);
      wait_valid(cyc);
      check("post_reset_latency", 64'(cyc), 64'(DEPTH));
      drain();

      // Random ops under random stall
      rand_stall = 1'b1;
      for (int k = 0; k < 24; k++) begin
         ru = 3'($urandom_range(0, 7));
         ro = 2'($urandom_range(0, 3));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         issue(ru, ro, ra, rb, 6'(k + 42), model(ru, ro, ra, rb));
      end
      rand_stall = 1'b0;
      tick();
      stall = 1'b0;
      drain();
      tick();
      check("final_idle", 64'(valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
